// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/LS memory arbiter.
package mem_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_RESP} arb_state_t;
   typedef enum logic {OWN_IF, OWN_LS} arb_owner_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bus between the core front-end/LSU, the arbiter and memory.
interface mem_arbiter_if;

   logic        if_req_valid;
   logic        if_req_ready;
   logic [31:0] if_req_addr;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;

   logic        ls_req_valid;
   logic        ls_req_ready;
   logic        ls_req_we;
   logic [2:0]  ls_req_funct3;
   logic [31:0] ls_req_addr;
   logic [31:0] ls_req_wdata;
   logic        ls_rsp_valid;
   logic [31:0] ls_rsp_data;

   logic        mem_write_mem;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_write_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_address;
   logic [31:0] mem_read_data;

   // Arbiter side
   modport slave (
      input  if_req_valid, if_req_addr,
      input  ls_req_valid, ls_req_we, ls_req_funct3, ls_req_addr, ls_req_wdata,
      input  mem_read_data,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      output ls_req_ready, ls_rsp_valid, ls_rsp_data,
      output mem_write_mem, mem_funct3, mem_write_address, mem_write_data,
      output mem_read_address
   );

   // Requesters and memory side
   modport master (
      output if_req_valid, if_req_addr,
      output ls_req_valid, ls_req_we, ls_req_funct3, ls_req_addr, ls_req_wdata,
      output mem_read_data,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
      input  mem_write_mem, mem_funct3, mem_write_address, mem_write_data,
      input  mem_read_address
   );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way picker: round-robin on contention, or fixed priority to req[1].
module rr_pick2 #(
   parameter bit RR_FAIR = 1'b1
) (
   input  logic [1:0] req,      // [0] = IF, [1] = LS
   input  logic       last_hi,  // 1 when req[1] won the previous grant
   output logic [1:0] gnt       // one-hot
);

   // Single requester wins outright; on a tie, the one not granted last
   // time wins when fair, otherwise req[1] always wins.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (RR_FAIR && last_hi) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory between instruction fetch and the LSU.
// Reads take two cycles (issue, then response with address/funct3 held so
// the memory's combinational byte/half extraction sees the same controls);
// stores complete in their accept cycle.
module mem_arbiter #(
   parameter bit RR_FAIR = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus
);
   import mem_arb_pkg::*;

   arb_state_t  state, state_nxt;
   arb_owner_t  owner, owner_nxt;
   arb_owner_t  last_grant, last_grant_nxt;
   logic [31:0] lat_addr, lat_addr_nxt;
   logic [2:0]  lat_f3, lat_f3_nxt;
   logic [1:0]  req, gnt;

   // New requests are only considered while no response is outstanding.
   assign req = (state == ARB_IDLE) ? {bus.ls_req_valid, bus.if_req_valid} : 2'b00;

   rr_pick2 #(.RR_FAIR(RR_FAIR)) u_pick (
      .req     (req),
      .last_hi (last_grant == OWN_LS),
      .gnt     (gnt)
   );

   // State and latched read controls; last_grant resets to LS so IF wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         owner      <= OWN_IF;
         last_grant <= OWN_LS;
         lat_addr   <= 32'd0;
         lat_f3     <= F3_W;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_grant <= last_grant_nxt;
         lat_addr   <= lat_addr_nxt;
         lat_f3     <= lat_f3_nxt;
      end
   end

   // Next state, handshakes and memory-port drive.
   always_comb begin
      state_nxt             = state;
      owner_nxt             = owner;
      last_grant_nxt        = last_grant;
      lat_addr_nxt          = lat_addr;
      lat_f3_nxt            = lat_f3;
      bus.if_req_ready      = 1'b0;
      bus.if_rsp_valid      = 1'b0;
      bus.if_rsp_data       = 32'd0;
      bus.ls_req_ready      = 1'b0;
      bus.ls_rsp_valid      = 1'b0;
      bus.ls_rsp_data       = 32'd0;
      bus.mem_write_mem     = 1'b0;
      bus.mem_funct3        = F3_W;
      bus.mem_write_address = 32'd0;
      bus.mem_write_data    = 32'd0;
      bus.mem_read_address  = 32'd0;

      case (state)
         ARB_IDLE: begin
            if (gnt[0]) begin
               bus.if_req_ready     = 1'b1;
               bus.mem_read_address = bus.if_req_addr;
               bus.mem_funct3       = F3_W;
               lat_addr_nxt         = bus.if_req_addr;
               lat_f3_nxt           = F3_W;
               owner_nxt            = OWN_IF;
               last_grant_nxt       = OWN_IF;
               state_nxt            = ARB_RESP;
            end else if (gnt[1]) begin
               bus.ls_req_ready = 1'b1;
               bus.mem_funct3   = bus.ls_req_funct3;
               last_grant_nxt   = OWN_LS;
               if (bus.ls_req_we) begin
                  bus.mem_write_mem     = 1'b1;
                  bus.mem_write_address = bus.ls_req_addr;
                  bus.mem_write_data    = bus.ls_req_wdata;
               end else begin
                  bus.mem_read_address = bus.ls_req_addr;
                  lat_addr_nxt         = bus.ls_req_addr;
                  lat_f3_nxt           = bus.ls_req_funct3;
                  owner_nxt            = OWN_LS;
                  state_nxt            = ARB_RESP;
               end
            end
         end
         ARB_RESP: begin
            bus.mem_read_address = lat_addr;
            bus.mem_funct3       = lat_f3;
            if (owner == OWN_IF) begin
               bus.if_rsp_valid = 1'b1;
               bus.if_rsp_data  = bus.mem_read_data;
            end else begin
               bus.ls_rsp_valid = 1'b1;
               bus.ls_rsp_data  = bus.mem_read_data;
            end
            state_nxt = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a word memory model behind the fair instance, a
// byte-level reference model checked every cycle, and directed vectors with
// literal expectations. A second, fixed-priority instance is checked directly.
module tb_mem_arbiter;

   logic clk;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   mem_arbiter_if bus();
   mem_arbiter_if fbus();

   mem_arbiter #(.RR_FAIR(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   mem_arbiter #(.RR_FAIR(1'b0)) dut_fix (.clk(clk), .rst_n(rst_n), .bus(fbus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] seed(input int i);
      if (i == 4) return 32'h0051_0113;
      return (32'(i) * 32'h0102_0305) ^ 32'hA5A5_0000;
   endfunction

   // ---------------- memory model (word array, shift/mask formatting) ----------------
   logic [31:0] mem_w [64];
   logic [31:0] rd_q;
   bit          mem_init = 1'b0;

   function automatic logic [31:0] mem_merge(input logic [31:0] w, input logic [31:0] d,
                                             input logic [2:0] f3, input logic [1:0] off);
      logic [31:0] m;
      case (f3[1:0])
         2'b00:   m = 32'h0000_00FF;
         2'b01:   m = 32'h0000_FFFF;
         default: m = 32'hFFFF_FFFF;
      endcase
      m = m << {off, 3'b000};
      return (w & ~m) | ((d << {off, 3'b000}) & m);
   endfunction

   function automatic logic [31:0] mem_fmt(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
      logic [31:0] s;
      s = w >> {off, 3'b000};
      case (f3)
         3'b000:  return {{24{s[7]}}, s[7:0]};
         3'b001:  return {{16{s[15]}}, s[15:0]};
         3'b100:  return {24'd0, s[7:0]};
         3'b101:  return {16'd0, s[15:0]};
         default: return w;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 64; i++) mem_w[i] <= seed(i);
         mem_init <= 1'b1;
      end else if (bus.mem_write_mem) begin
         mem_w[bus.mem_write_address[7:2]] <= mem_merge(mem_w[bus.mem_write_address[7:2]],
            bus.mem_write_data, bus.mem_funct3, bus.mem_write_address[1:0]);
      end
      rd_q <= mem_w[bus.mem_read_address[7:2]];
   end

   assign bus.mem_read_data  = mem_fmt(rd_q, bus.mem_funct3, bus.mem_read_address[1:0]);
   assign fbus.mem_read_data = 32'h1234_5678;

   // ---------------- reference model (byte array, request/response scoreboard) ----------------
   logic [7:0]  ref_b [256];
   bit          m_pend;
   bit          m_own_ls;
   bit          m_last_ls;
   logic [31:0] m_addr;
   logic [2:0]  m_f3;

   initial begin
      for (int i = 0; i < 64; i++) begin
         logic [31:0] w;
         w = seed(i);
         for (int k = 0; k < 4; k++) ref_b[4*i+k] = w[8*k +: 8];
      end
   end

   function automatic int nbytes(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      int          n;
      logic [31:0] v;
      n = nbytes(f3);
      v = 32'd0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_b[a[7:0] + 8'(k)];
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      return v;
   endfunction

   // Compare the fair instance against the model once per cycle, then advance the model.
   always @(negedge clk) begin : model_chk
      logic [1:0]  e_rdy, e_rsp;
      logic [31:0] e_ifd, e_lsd, e_ra, e_wa, e_wd;
      logic [2:0]  e_f3;
      logic        e_wm, do_ra, do_w;
      e_rdy = 2'b00; e_rsp = 2'b00; e_ifd = 32'd0; e_lsd = 32'd0;
      e_ra = 32'd0; e_wa = 32'd0; e_wd = 32'd0; e_f3 = 3'b010; e_wm = 1'b0;
      do_ra = 1'b1; do_w = 1'b1;
      if (!rst_n) begin
         m_pend = 1'b0;
         m_last_ls = 1'b1;
      end else if (m_pend) begin
         e_ra = m_addr; e_f3 = m_f3; do_w = 1'b0;
         if (m_own_ls) begin e_rsp = 2'b10; e_lsd = ref_load(m_f3, m_addr); end
         else          begin e_rsp = 2'b01; e_ifd = ref_load(3'b010, m_addr); end
         m_pend = 1'b0;
      end else if (bus.if_req_valid && (!bus.ls_req_valid || m_last_ls)) begin
         e_rdy = 2'b01; e_ra = bus.if_req_addr; do_w = 1'b0;
         m_pend = 1'b1; m_own_ls = 1'b0; m_addr = bus.if_req_addr; m_f3 = 3'b010;
         m_last_ls = 1'b0;
      end else if (bus.ls_req_valid) begin
         e_rdy = 2'b10; e_f3 = bus.ls_req_funct3; m_last_ls = 1'b1;
         if (bus.ls_req_we) begin
            e_wm = 1'b1; e_wa = bus.ls_req_addr; e_wd = bus.ls_req_wdata; do_ra = 1'b0;
            for (int k = 0; k < nbytes(bus.ls_req_funct3); k++)
               ref_b[bus.ls_req_addr[7:0] + 8'(k)] = bus.ls_req_wdata[8*k +: 8];
         end else begin
            e_ra = bus.ls_req_addr; do_w = 1'b0;
            m_pend = 1'b1; m_own_ls = 1'b1; m_addr = bus.ls_req_addr; m_f3 = bus.ls_req_funct3;
         end
      end
      chk("model ready{ls,if}", 32'({bus.ls_req_ready, bus.if_req_ready}), 32'(e_rdy));
      chk("model rsp_valid{ls,if}", 32'({bus.ls_rsp_valid, bus.if_rsp_valid}), 32'(e_rsp));
      chk("model if_rsp_data", bus.if_rsp_data, e_ifd);
      chk("model ls_rsp_data", bus.ls_rsp_data, e_lsd);
      chk("model mem_write_mem", 32'(bus.mem_write_mem), 32'(e_wm));
      chk("model mem_funct3", 32'(bus.mem_funct3), 32'(e_f3));
      if (do_ra) chk("model mem_read_address", bus.mem_read_address, e_ra);
      if (do_w) begin
         chk("model mem_write_address", bus.mem_write_address, e_wa);
         chk("model mem_write_data", bus.mem_write_data, e_wd);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.if_req_valid = 1'b0;  bus.if_req_addr = 32'd0;
      bus.ls_req_valid = 1'b0;  bus.ls_req_we = 1'b0;  bus.ls_req_funct3 = 3'b010;
      bus.ls_req_addr = 32'd0;  bus.ls_req_wdata = 32'd0;
   endtask

   task automatic fidle();
      fbus.if_req_valid = 1'b0;  fbus.if_req_addr = 32'd0;
      fbus.ls_req_valid = 1'b0;  fbus.ls_req_we = 1'b0;  fbus.ls_req_funct3 = 3'b010;
      fbus.ls_req_addr = 32'd0;  fbus.ls_req_wdata = 32'd0;
   endtask

   task automatic ls_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
      cyc();
      idle();
      bus.ls_req_valid = 1'b1; bus.ls_req_we = 1'b1; bus.ls_req_funct3 = f3;
      bus.ls_req_addr = a; bus.ls_req_wdata = d;
      #5;
      chk("store ls_req_ready", 32'(bus.ls_req_ready), 32'd1);
      chk("store mem_write_mem", 32'(bus.mem_write_mem), 32'd1);
   endtask

   task automatic ls_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
      cyc();
      idle();
      bus.ls_req_valid = 1'b1; bus.ls_req_funct3 = f3; bus.ls_req_addr = a;
      #5;
      chk({nm, " accept ready"}, 32'(bus.ls_req_ready), 32'd1);
      chk({nm, " accept no write"}, 32'(bus.mem_write_mem), 32'd0);
      cyc();
      idle();
      #5;
      chk({nm, " rsp_valid"}, 32'(bus.ls_rsp_valid), 32'd1);
      chk({nm, " rsp_data"}, bus.ls_rsp_data, exp);
      chk({nm, " rsp no write"}, 32'(bus.mem_write_mem), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      fidle();
      repeat (2) cyc();
      chk("reset mem_funct3", 32'(bus.mem_funct3), 32'd2);
      chk("reset readies", 32'({bus.ls_req_ready, bus.if_req_ready}), 32'd0);
      chk("reset mem_write_mem", 32'(bus.mem_write_mem), 32'd0);
      rst_n = 1'b1;

      // IF only: accept in cycle 0, word in cycle 1, nothing accepted in cycle 1
      cyc();
      bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h0000_0010;
      #5;
      chk("if0 if_req_ready", 32'(bus.if_req_ready), 32'd1);
      cyc();
      #5;
      chk("if1 if_rsp_valid", 32'(bus.if_rsp_valid), 32'd1);
      chk("if1 if_rsp_data", bus.if_rsp_data, 32'h0051_0113);
      chk("if1 if_req_ready", 32'(bus.if_req_ready), 32'd0);

      // Byte/half loads of a stored word
      ls_store(32'h20, 3'b010, 32'h8000_00FF);
      ls_load("lb 0x20", 3'b000, 32'h20, 32'hFFFF_FFFF);
      ls_load("lbu 0x23", 3'b100, 32'h23, 32'h0000_0080);
      ls_load("lh 0x22", 3'b001, 32'h22, 32'hFFFF_8000);
      ls_load("lhu 0x20", 3'b101, 32'h20, 32'h0000_00FF);

      // Store then immediate load of the same word
      ls_store(32'h40, 3'b010, 32'hDEAD_BEEF);
      ls_load("lw 0x40", 3'b010, 32'h40, 32'hDEAD_BEEF);

      // Round-robin contention from reset
      cyc();
      idle();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h10;
      bus.ls_req_valid = 1'b1; bus.ls_req_funct3 = 3'b010; bus.ls_req_addr = 32'h20;
      for (int c = 0; c < 8; c++) begin
         if (c != 0) cyc();
         #5;
         if (c % 2 == 0) begin
            chk("rr if_req_ready", 32'(bus.if_req_ready), 32'(c % 4 == 0));
            chk("rr ls_req_ready", 32'(bus.ls_req_ready), 32'(c % 4 == 2));
         end else begin
            chk("rr if_rsp_valid", 32'(bus.if_rsp_valid), 32'(c % 4 == 1));
            chk("rr ls_rsp_valid", 32'(bus.ls_rsp_valid), 32'(c % 4 == 3));
         end
      end
      chk("rr last ls_rsp_data", bus.ls_rsp_data, 32'h8000_00FF);
      cyc();
      idle();

      // Fixed priority: LS always wins while valid
      fbus.if_req_valid = 1'b1; fbus.if_req_addr = 32'h10;
      fbus.ls_req_valid = 1'b1; fbus.ls_req_funct3 = 3'b010; fbus.ls_req_addr = 32'h20;
      for (int c = 0; c < 6; c++) begin
         if (c != 0) cyc();
         #5;
         chk("fix if_req_ready", 32'(fbus.if_req_ready), 32'd0);
         if (c % 2 == 0) begin
            chk("fix ls_req_ready", 32'(fbus.ls_req_ready), 32'd1);
         end else begin
            chk("fix ls_rsp_valid", 32'(fbus.ls_rsp_valid), 32'd1);
            chk("fix ls_rsp_data", fbus.ls_rsp_data, 32'h1234_5678);
            chk("fix if_rsp_valid", 32'(fbus.if_rsp_valid), 32'd0);
         end
      end
      cyc();
      fbus.ls_req_valid = 1'b0;
      #5;
      chk("fix if granted after ls drops", 32'(fbus.if_req_ready), 32'd1);
      cyc();
      fidle();
      #5;
      chk("fix if_rsp_valid", 32'(fbus.if_rsp_valid), 32'd1);

      // Reset while a response is pending
      cyc();
      bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h10;
      #5;
      chk("rstresp accept", 32'(bus.if_req_ready), 32'd1);
      cyc();
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstresp if_rsp_valid", 32'(bus.if_rsp_valid), 32'd0);
      chk("rstresp mem_funct3", 32'(bus.mem_funct3), 32'd2);
      chk("rstresp mem_read_address", bus.mem_read_address, 32'd0);
      cyc();
      rst_n = 1'b1;
      bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h10;
      #5;
      chk("post-reset if accept", 32'(bus.if_req_ready), 32'd1);
      cyc();
      idle();
      #5;
      chk("post-reset if_rsp_valid", 32'(bus.if_rsp_valid), 32'd1);
      chk("post-reset if_rsp_data", bus.if_rsp_data, 32'h0051_0113);
      repeat (2) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RV32I memory block between the instruction-fetch unit (IF) and the load/store unit (LS).
- Memory reads are synchronous with 1-cycle latency. Read-data byte/half extraction is combinational on the *current* funct3 and read_address[1:0].
- The arbiter therefore sequences every read as ISSUE then RESP, holding funct3/address through RESP, and drives the memory write port for stores.
- Sits between the core front-end/LSU and the memory instance; all memory-side ports connect 1:1 to the memory.

Parameters:
- RR_FAIR, 1: 1 = round-robin between IF and LS on contention; 0 = fixed priority, LS always wins.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- if_req_valid  in  1  fetch request pending
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  32  fetch byte address
- if_rsp_valid  out  1  fetch data valid (1-cycle pulse)
- if_rsp_data  out  32  fetched instruction word
- ls_req_valid  in  1  load/store request pending
- ls_req_ready  out  1  load/store accepted this cycle
- ls_req_we  in  1  1 = store, 0 = load
- ls_req_funct3  in  3  RV32I funct3 of the load/store
- ls_req_addr  in  32  byte address
- ls_req_wdata  in  32  store data
- ls_rsp_valid  out  1  load data valid (1-cycle pulse); never asserted for stores
- ls_rsp_data  out  32  formatted load data
- mem_write_mem  out  1  memory write enable
- mem_funct3  out  3  memory funct3
- mem_write_address  out  32  memory write address
- mem_write_data  out  32  memory write data
- mem_read_address  out  32  memory read address
- mem_read_data  in  32  memory formatted read data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- States: ARB_IDLE and ARB_RESP. Registers: state, owner (IF/LS), last_grant, lat_addr[31:0], lat_f3[2:0].
- Reset values:
  - state = ARB_IDLE, last_grant = LS, so IF wins the first tie.
  - lat_addr = 0, lat_f3 = 3'b010.
  - All ready and rsp_valid outputs = 0, mem_write_mem = 0.
  - mem_* address/data outputs = 0, mem_funct3 = 3'b010.
- Grant in ARB_IDLE (combinational):
  - Only one valid: that requester is granted.
  - Both valid: RR_FAIR=1 grants the requester not equal to last_grant; RR_FAIR=0 grants LS.
  - The granted requester's ready = 1 in the same cycle. The other ready = 0.
  - Ready is never asserted without the matching valid.
- IF grant:
  - mem_read_address = if_req_addr, mem_funct3 = 3'b010.
  - Latch the address, funct3 = 010, owner = IF; next state ARB_RESP.
- LS load grant (ls_req_we=0):
  - mem_read_address = ls_req_addr, mem_funct3 = ls_req_funct3.
  - Latch both, owner = LS; next state ARB_RESP.
- LS store grant (ls_req_we=1):
  - mem_write_mem = 1; mem_write_address/mem_write_data/mem_funct3 taken from the LS request.
  - Stay in ARB_IDLE. No response pulse; the store completes at this edge.
- ARB_RESP (exactly 1 cycle):
  - mem_read_address = lat_addr, mem_funct3 = lat_f3, mem_write_mem = 0.
  - Owner's rsp_valid = 1; its rsp_data = mem_read_data (combinational pass-through).
  - Both ready = 0; next state ARB_IDLE.
- last_grant updates on every accepted request, stores included.
- Throughput: reads 1 per 2 cycles; stores 1 per cycle; read latency = 1 cycle after acceptance.
- Responses have no backpressure; requesters must accept the rsp_valid pulse.
- Ordering: a store accepted in cycle N is visible to a read issued in cycle N+1 or later.
- rsp_data is don't-care when rsp_valid = 0; it is driven to 0 for determinism.
- Idle outputs (ARB_IDLE, no grant): mem_write_mem = 0, mem_funct3 = 3'b010, addresses/data = 0.
- Reset mid-ARB_RESP: pending response is dropped, no rsp_valid; state returns to ARB_IDLE.
- Requests whose valid deasserts without acceptance are simply not served.
- Addresses are passed through unchanged; alignment and range are the memory's concern.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_RESP} arb_state_t
  - typedef enum logic {OWN_IF, OWN_LS} arb_owner_t
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
- One sub-module, rr_pick2: 2-way round-robin/fixed-priority picker (inputs: two valids, last_grant, RR_FAIR; output: one-hot grant).

Test Plan:
- IF only, addr 0x0000_0010, mem word[4] = 0x0051_0113:
  - if_req_ready = 1 in cycle 0.
  - if_rsp_valid = 1 with data 0x0051_0113 in cycle 1.
  - No request served in cycle 1.
- LS byte load: store 0x8000_00FF at 0x20 via LS (funct3 010).
  - lb at 0x20 returns 0xFFFF_FFFF.
  - lbu at 0x23 returns 0x0000_0080.
  - lh at 0x22 returns 0xFFFF_8000.
- Contention, RR_FAIR=1, both valid continuously from reset:
  - Grants IF, LS, IF, LS on accept cycles 0, 2, 4, 6.
  - rsp_valid pulses on cycles 1, 3, 5, 7 to the matching owner.
- RR_FAIR=0, both valid: LS granted every accept cycle; IF never granted until ls_req_valid drops.
- Store-then-load:
  - sw 0xDEAD_BEEF to 0x40 at cycle 0; lw 0x40 accepted at cycle 1.
  - ls_rsp_data = 0xDEAD_BEEF at cycle 2; mem_write_mem high only in cycle 0.
- Reset in ARB_RESP: assert rst_n = 0 mid-cycle.
  - Outputs go to reset values immediately; no rsp_valid.
  - After release, the next IF request is served normally.
